// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state type, owner codes and starvation counter sizing
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_LDR = 1'b1;
    function automatic int cnt_w(input int max);
        return max < 1 ? 1 : $clog2(max + 1);
    endfunction
    localparam int STARVE_MAX_DEF = 8;
    localparam int STARVE_W = cnt_w(STARVE_MAX_DEF);
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner choice between CPU and loader
// ports: cpu_req/ldr_req/ldr_lock requests, last_owner and starve_cnt history, winner result
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CW = cnt_w(STARVE_MAX)
) (
    input  logic          cpu_req,
    input  logic          ldr_req,
    input  logic          ldr_lock,
    input  logic          last_owner,
    input  logic [CW-1:0] starve_cnt,
    output logic          winner
);
    logic keep_ldr;
    // the lock only extends an existing loader tenure, and only until the CPU has waited long enough
    assign keep_ldr = ldr_lock && last_owner == OWNER_LDR && starve_cnt < CW'(STARVE_MAX);
    assign winner = !ldr_req ? OWNER_CPU :
                    !cpu_req ? OWNER_LDR :
                    keep_ldr ? OWNER_LDR : ~last_owner;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the CPU and a loader port
// ports: cpu_* and ldr_* req/ack handshake sets, mem_* memory side, busy/owner status
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int READ_LAT = 1,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    input  logic              ldr_lock,
    output logic              ldr_gnt,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);
    localparam int CW = cnt_w(STARVE_MAX);
    state_t        state;
    logic          last_owner, we_q, winner;
    logic [CW-1:0] starve_cnt;
    logic [1:0]    wcnt;
    mem_arb_pick #(.STARVE_MAX(STARVE_MAX), .CW(CW)) u_pick (
        .cpu_req(cpu_req),
        .ldr_req(ldr_req),
        .ldr_lock(ldr_lock),
        .last_owner(last_owner),
        .starve_cnt(starve_cnt),
        .winner(winner)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= OWNER_LDR;
            starve_cnt <= '0;
            wcnt       <= '0;
            we_q       <= 1'b0;
            cpu_gnt    <= 1'b0;
            cpu_ack    <= 1'b0;
            cpu_rdata  <= '0;
            ldr_gnt    <= 1'b0;
            ldr_ack    <= 1'b0;
            ldr_rdata  <= '0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            owner      <= OWNER_CPU;
        end else begin
            case (state)
                IDLE: if (cpu_req || ldr_req) begin
                    state      <= ACCESS;
                    busy       <= 1'b1;
                    owner      <= winner;
                    last_owner <= winner;
                    we_q       <= winner ? ldr_we : cpu_we;
                    mem_write  <= winner ? ldr_we : cpu_we;
                    mem_addr   <= winner ? ldr_addr : cpu_addr;
                    mem_wdata  <= winner ? ldr_wdata : cpu_wdata;
                    cpu_gnt    <= winner == OWNER_CPU;
                    ldr_gnt    <= winner == OWNER_LDR;
                    // counts loader grants the CPU had to sit through; saturates at STARVE_MAX
                    starve_cnt <= (winner == OWNER_CPU || !cpu_req) ? '0 :
                                  starve_cnt == CW'(STARVE_MAX) ? starve_cnt : starve_cnt + CW'(1);
                end
                ACCESS: begin
                    state     <= WAIT;
                    mem_write <= 1'b0;
                    wcnt      <= 2'(READ_LAT - 1);
                end
                WAIT: if (wcnt == 2'd0) begin
                    state   <= RESP;
                    cpu_ack <= owner == OWNER_CPU;
                    ldr_ack <= owner == OWNER_LDR;
                    if (!we_q && owner == OWNER_CPU) cpu_rdata <= mem_rdata;
                    if (!we_q && owner == OWNER_LDR) ldr_rdata <= mem_rdata;
                end else begin
                    wcnt <= wcnt - 2'd1;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    cpu_gnt <= 1'b0;
                    ldr_gnt <= 1'b0;
                    cpu_ack <= 1'b0;
                    ldr_ack <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, timing and reset for mem_port_arbiter
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cpu_req = 0, cpu_we = 0, ldr_req = 0, ldr_we = 0, ldr_lock = 0;
    logic [7:0] cpu_addr = 0, cpu_wdata = 0, ldr_addr = 0, ldr_wdata = 0;
    logic cpu_gnt, cpu_ack, ldr_gnt, ldr_ack, mem_write, busy, owner;
    logic [7:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
    logic c3_req = 0;
    logic c3_gnt, c3_ack, l3_gnt, l3_ack, m3_write, busy3, owner3;
    logic [7:0] c3_rdata, l3_rdata, m3_addr, m3_wdata, m3_rdata;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.READ_LAT(1)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt), .ldr_ack(ldr_ack), .ldr_rdata(ldr_rdata),
        .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    mem_port_arbiter #(.READ_LAT(3)) dut3 (
        .clk(clk), .reset(reset),
        .cpu_req(c3_req), .cpu_we(1'b0), .cpu_addr(8'h44), .cpu_wdata(8'h00),
        .cpu_gnt(c3_gnt), .cpu_ack(c3_ack), .cpu_rdata(c3_rdata),
        .ldr_req(1'b0), .ldr_we(1'b0), .ldr_addr(8'h00), .ldr_wdata(8'h00),
        .ldr_lock(1'b0), .ldr_gnt(l3_gnt), .ldr_ack(l3_ack), .ldr_rdata(l3_rdata),
        .mem_write(m3_write), .mem_addr(m3_addr), .mem_wdata(m3_wdata), .mem_rdata(m3_rdata),
        .busy(busy3), .owner(owner3)
    );

    // memory models: 1-cycle and 3-cycle registered read latency
    logic [7:0] mem [256];
    logic [7:0] mem3 [256];
    logic [7:0] rd1, p0, p1, p2;
    bit mem_ready;
    always @(posedge clk) begin
        if (!mem_ready) begin
            mem[8'h10] <= 8'h5A;
            mem3[8'h44] <= 8'h9B;
            mem_ready <= 1'b1;
        end else begin
            if (mem_write) mem[mem_addr] <= mem_wdata;
            if (m3_write) mem3[m3_addr] <= m3_wdata;
        end
        rd1 <= mem[mem_addr];
        p0 <= mem3[m3_addr];
        p1 <= p0;
        p2 <= p1;
    end
    assign mem_rdata = rd1;
    assign m3_rdata = p2;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cpu_req = 0; ldr_req = 0; ldr_lock = 0; c3_req = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_ack(input string nm, output logic who, output int lat);
        lat = 0;
        who = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (cpu_ack || ldr_ack) begin
                who = ldr_ack;
                lat = c;
                break;
            end
        end
        if (lat == 0) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic txn(input string nm, input logic ldr, input logic we, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] exp);
        int lat, wr;
        lat = 0;
        wr = 0;
        @(negedge clk);
        if (ldr) begin
            ldr_req = 1; ldr_we = we; ldr_addr = a; ldr_wdata = d;
        end else begin
            cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (mem_write) wr++;
            if (c == 1) begin
                chk({nm, "_gnt"}, {cpu_gnt, ldr_gnt}, ldr ? 2'b01 : 2'b10);
                chk({nm, "_owner"}, {busy, owner}, {1'b1, ldr});
                chk({nm, "_addr"}, mem_addr, a);
                if (we) chk({nm, "_wdata"}, mem_wdata, d);
            end
            if (cpu_ack || ldr_ack) begin
                lat = c;
                break;
            end
        end
        chk({nm, "_lat"}, lat, 3);
        chk({nm, "_ack"}, {cpu_ack, ldr_ack, cpu_gnt, ldr_gnt}, ldr ? 4'b0101 : 4'b1010);
        if (!we) chk({nm, "_rdata"}, ldr ? ldr_rdata : cpu_rdata, exp);
        cpu_req = 0;
        ldr_req = 0;
        @(negedge clk);
        chk({nm, "_idle"}, {busy, cpu_ack, ldr_ack, cpu_gnt, ldr_gnt}, 0);
        chk({nm, "_wr_cnt"}, wr, we ? 1 : 0);
    endtask

    typedef struct {
        logic ldr;
        logic we;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic who;
        int lat, acks, first;
        tbl[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h5A};
        tbl[1] = '{1'b1, 1'b1, 8'h20, 8'hC3, 8'h00};
        tbl[2] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'hC3};
        tbl[3] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'h5A};
        tbl[4] = '{1'b0, 1'b1, 8'h30, 8'h7E, 8'h00};
        tbl[5] = '{1'b1, 1'b0, 8'h30, 8'h00, 8'h7E};
        tbl[6] = '{1'b1, 1'b1, 8'hFF, 8'h01, 8'h00};
        tbl[7] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h01};
        do_reset();
        @(negedge clk);
        chk("reset_ctl", {busy, cpu_gnt, ldr_gnt, cpu_ack, ldr_ack, mem_write}, 0);
        chk("reset_data", {mem_addr, mem_wdata, cpu_rdata, ldr_rdata}, 0);
        chk("reset_dut3", {busy3, c3_gnt, c3_ack, m3_write}, 0);

        for (int i = 0; i < 8; i++) txn($sformatf("vec%0d", i), tbl[i].ldr, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].exp);

        do_reset();
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        ldr_req = 1; ldr_we = 0; ldr_addr = 8'h20;
        for (int t = 0; t < 6; t++) begin
            wait_ack($sformatf("tie%0d", t), who, lat);
            chk($sformatf("tie%0d_who", t), who, t % 2);
            chk($sformatf("tie%0d_rdata", t), who ? ldr_rdata : cpu_rdata, who ? 8'hC3 : 8'h5A);
        end
        cpu_req = 0;
        ldr_req = 0;

        do_reset();
        @(negedge clk);
        ldr_lock = 1;
        cpu_req = 1; ldr_req = 1;
        for (int t = 0; t < 10; t++) begin
            wait_ack($sformatf("lock%0d", t), who, lat);
            chk($sformatf("lock%0d_who", t), who, (t == 8) ? 0 : 1);
            if (t == 8) chk("lock_starve_clr", dut.starve_cnt, 0);
        end
        cpu_req = 0;
        ldr_req = 0;
        ldr_lock = 0;

        do_reset();
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
        @(negedge clk);
        chk("rst_mid_gnt", cpu_gnt, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_ctl", {busy, cpu_gnt, ldr_gnt, cpu_ack, ldr_ack, mem_write}, 0);
        chk("rst_mid_data", {mem_addr, mem_wdata, cpu_rdata, ldr_rdata}, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_regrant", cpu_gnt, 1);
        wait_ack("rst_again", who, lat);
        chk("rst_again_lat", lat, 2);
        chk("rst_again_rdata", {who, cpu_rdata}, {1'b0, 8'h5A});
        cpu_req = 0;

        do_reset();
        @(negedge clk);
        c3_req = 1;
        acks = 0;
        first = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("drop_gnt", c3_gnt, 1);
                c3_req = 0;
            end
            if (c3_ack) begin
                acks++;
                if (first == 0) begin
                    first = c;
                    chk("drop_rdata", c3_rdata, 8'h9B);
                end
            end
        end
        chk("drop_lat", first, 5);
        chk("drop_acks", acks, 1);
        chk("drop_idle", busy3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-port data memory between the CPU control path and a program loader/debug port. Each requester uses a req/ack handshake. The arbiter picks one owner, drives the memory's write strobe, address and write data, captures read data after a fixed latency, and returns it to the owner. It sits between the control unit/MAR/dest bus and the memory instance in the top level.

Parameters:
DATA_W, 8, data width of memory and requester data ports
ADDR_W, 8, address width
READ_LAT, 1, cycles from ACCESS until mem_rdata is valid (legal values 1..3)
STARVE_MAX, 8, maximum consecutive loader grants under ldr_lock while cpu_req is pending

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
cpu_req  in  1  CPU request; held until cpu_ack
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU owns the port
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  DATA_W  read data, valid with cpu_ack
ldr_req, ldr_we, ldr_addr, ldr_wdata  in  1/1/ADDR_W/DATA_W  loader request set, same meaning as the CPU set
ldr_lock  in  1  loader asks to keep the port across back-to-back requests
ldr_gnt, ldr_ack, ldr_rdata  out  1/1/DATA_W  loader response set, same meaning as the CPU set
mem_write  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  state is not IDLE
owner  out  1  0 = CPU, 1 = loader; valid while busy

Behaviour:
- All outputs are registered.
- Reset is synchronous and active-high and aborts any transaction in progress, with no ack. After reset:
  - state = IDLE
  - all gnt/ack = 0, mem_write = 0
  - mem_addr, mem_wdata, cpu_rdata, ldr_rdata = 0
  - last_owner = loader, so the CPU wins the first tie
  - starve_cnt = 0
- State machine: IDLE -> ACCESS -> WAIT (READ_LAT cycles) -> RESP -> IDLE. Non-pipelined; one transaction at a time.
- IDLE: requests are sampled every cycle. When any req is high, the arbiter latches the winner's we/addr/wdata and moves to ACCESS.
- ACCESS (1 cycle):
  - mem_addr and mem_wdata come from the latched request.
  - mem_write = latched we.
  - Winner's gnt = 1, busy = 1.
- WAIT:
  - mem_addr is held and mem_write = 0.
  - On the last WAIT cycle, the owner's rdata register captures mem_rdata if the transaction is a read. For writes, rdata is unchanged.
- RESP (1 cycle): owner's ack = 1 and gnt stays 1, then the state returns to IDLE.
- gnt is high from ACCESS through RESP inclusive. The loser's gnt and ack stay 0.
- Latency, req seen in IDLE to ack: READ_LAT + 2 cycles. Reads and writes use identical timing.
- Requesters drop or renew req on the edge that ends RESP. IDLE always lasts at least 1 cycle, so the minimum period is READ_LAT + 3 cycles.
- req dropped after acceptance: the transaction completes normally, using the latched values.
- Arbitration in IDLE, both requests high:
  - If ldr_lock = 1, last_owner = loader and starve_cnt < STARVE_MAX -> grant the loader.
  - Otherwise round-robin: grant the requester that is not last_owner.
  - A single request is always granted. last_owner updates on every grant.
- Starvation counter:
  - starve_cnt increments on each loader grant made while cpu_req = 1.
  - It clears on a CPU grant, and when cpu_req = 0 at a loader grant.
  - When starve_cnt = STARVE_MAX, the CPU is forced to win.
  - The counter saturates and never wraps.
- ldr_lock with ldr_req = 0 has no effect.

Decomposition:
- Package mem_arb_pkg:
  - state typedef (IDLE, ACCESS, WAIT, RESP)
  - OWNER_CPU = 1'b0, OWNER_LDR = 1'b1
  - width of starve_cnt, sized to hold STARVE_MAX
- Sub-module mem_arb_pick: the combinational winner decision.
  - Inputs: cpu_req, ldr_req, ldr_lock, last_owner, starve_cnt.
  - Output: winner.
  - Unit-testable on its own. The top module holds the FSM, the latches and the counters.

Test Plan:
- CPU read: mem holds 0x5A at addr 0x10; cpu_req with we=0, addr=0x10 -> cpu_gnt on the next cycle; cpu_ack with cpu_rdata=0x5A exactly 3 cycles after req is sampled (READ_LAT=1); mem_write never asserted.
- Loader write then CPU read: ldr write 0xC3 to 0x20 -> mem_write=1 for exactly 1 cycle with mem_addr=0x20 and mem_wdata=0xC3; ldr_ack 3 cycles later. Then a CPU read of 0x20 returns 0xC3.
- Tie after reset: both req in the same cycle -> CPU granted first, then the loader. Grants alternate over 6 transactions.
- Lock and starvation: ldr_lock=1 with continuous ldr_req and cpu_req -> 8 consecutive loader grants, then a CPU grant, and starve_cnt clears to 0.
- Reset mid-transaction: assert reset during WAIT -> the next cycle has busy=0, no ack, all outputs 0. The pending CPU req is re-granted after reset deasserts.
- req dropped in ACCESS: cpu_req falls after acceptance -> the transaction still completes and cpu_ack pulses once. READ_LAT=3 build: ack arrives 5 cycles after req is sampled.
